bn254_func_dispatcher: RTL and testbench

//  Command front-end for new_sequencer in the BN254 pairing core. Queues function

---
 rtl/bn254_func_dispatcher_if.sv | 30 +++
 rtl/bn254_func_dispatcher.sv | 130 +++++++++++++
 tb/tb_bn254_func_dispatcher.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bn254_func_dispatcher_if.sv
// Host/sequencer-facing signal bundle of the BN254 function dispatcher.
// The dispatcher uses the slave side; the host and sequencer use the master side.
interface bn254_func_dispatcher_if #(
  parameter int FUNC_W = 4,
  parameter int CNT_W  = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [FUNC_W-1:0] cmd_func;
  logic              run;
  logic [FUNC_W-1:0] n_func;
  logic              seq_busy;
  logic              done;
  logic [FUNC_W-1:0] done_func;
  logic [CNT_W-1:0]  done_cycles;
  logic              err;
  logic              host_req;
  logic              host_grant;
  logic              idle;

  modport slave (
    input  cmd_valid, cmd_func, seq_busy, host_req,
    output cmd_ready, run, n_func, done, done_func, done_cycles, err, host_grant, idle
  );

  modport master (
    output cmd_valid, cmd_func, seq_busy, host_req,
    input  cmd_ready, run, n_func, done, done_func, done_cycles, err, host_grant, idle
  );
endinterface

// File: rtl/bn254_func_dispatcher.sv
// Command front-end for the BN254 sequencer: queues function numbers, launches them
// one at a time, times each run and arbitrates the host register-file port.
module bn254_func_dispatcher #(
  parameter int DEPTH     = 4,
  parameter int FUNC_W    = 4,
  parameter int START_TMO = 8,
  parameter int CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  swrst,
  bn254_func_dispatcher_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_HOST, S_LAUNCH, S_WAIT_BUSY, S_RUN} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [FUNC_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_fair;
  logic [FUNC_W-1:0] r_n_func;
  logic              r_done;
  logic [FUNC_W-1:0] r_done_func;
  logic [CNT_W-1:0]  r_done_cycles;
  logic              r_err;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_timeout;
  logic              w_run;
  logic              w_grant;
  logic              w_idle;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push    = bus.cmd_valid && !w_full;
  assign w_pop     = (r_state == S_LAUNCH);
  assign w_timeout = (r_cnt >= CNT_W'(START_TMO));

  // FIFO storage carries no reset; a flush only moves the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= bus.cmd_func;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      r_state <= S_IDLE;
    else if (swrst) r_state <= S_IDLE;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.host_req && (!r_fair || w_empty)) w_state_next = S_HOST;
        else if (!w_empty)                        w_state_next = S_LAUNCH;
      end
      S_HOST:      if (!bus.host_req) w_state_next = S_IDLE;
      S_LAUNCH:    w_state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (bus.seq_busy)  w_state_next = S_RUN;
        else if (w_timeout) w_state_next = S_IDLE;
      end
      S_RUN:       if (!bus.seq_busy) w_state_next = S_IDLE;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_run   = (r_state == S_LAUNCH);
    w_grant = (r_state == S_HOST);
    w_idle  = (r_state == S_IDLE) && w_empty;
  end

  // n_func is loaded while IDLE picks a launch so it is already valid with run.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0; r_rptr <= '0; r_cnt <= '0; r_fair <= 1'b0; r_n_func <= '0;
      r_done <= 1'b0; r_done_func <= '0; r_done_cycles <= '0; r_err <= 1'b0;
    end else if (swrst) begin
      r_wptr <= '0; r_rptr <= '0; r_cnt <= '0; r_fair <= 1'b0; r_n_func <= '0;
      r_done <= 1'b0; r_done_func <= '0; r_done_cycles <= '0; r_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case (r_state)
        S_IDLE: if (w_state_next == S_LAUNCH) r_n_func <= r_mem[r_rptr[AW-1:0]];
        S_HOST: if (!bus.host_req) r_fair <= 1'b1;
        S_LAUNCH: begin
          r_cnt  <= CNT_W'(1);
          r_fair <= 1'b0;
        end
        S_WAIT_BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (!bus.seq_busy && w_timeout) begin
            r_err         <= 1'b1;
            r_done        <= 1'b1;
            r_done_func   <= r_n_func;
            r_done_cycles <= r_cnt;
          end
        end
        S_RUN: begin
          if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
          if (!bus.seq_busy) begin
            r_done        <= 1'b1;
            r_done_func   <= r_n_func;
            r_done_cycles <= r_cnt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cmd_ready   = !w_full;
  assign bus.run         = w_run;
  assign bus.n_func      = r_n_func;
  assign bus.done        = r_done;
  assign bus.done_func   = r_done_func;
  assign bus.done_cycles = r_done_cycles;
  assign bus.err         = r_err;
  assign bus.host_grant  = w_grant;
  assign bus.idle        = w_idle;
endmodule

// File: tb/tb_bn254_func_dispatcher.sv
// Directed bench for bn254_func_dispatcher: a vector table of single commands plus
// hand sequences for FIFO full, host arbitration, timeout, soft and async reset.
module tb_bn254_func_dispatcher;
  localparam int FUNC_W = 4, CNT_W = 32, DEPTH = 4, START_TMO = 8;

  typedef struct {
    logic [FUNC_W-1:0] func;
    int                bs;
    int                be;
    bit                busy_en;
    int                exp_cycles;
    bit                exp_err;
  } vec_t;

  typedef struct {
    logic [FUNC_W-1:0] func;
    logic [CNT_W-1:0]  cycles;
    logic              err;
    int                at;
  } done_t;

  logic clk = 1'b0, rstn = 1'b0, swrst = 1'b0;
  always #5 clk = ~clk;

  bn254_func_dispatcher_if #(.FUNC_W(FUNC_W), .CNT_W(CNT_W)) bus ();

  bn254_func_dispatcher #(.DEPTH(DEPTH), .FUNC_W(FUNC_W), .START_TMO(START_TMO), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .swrst (swrst),
    .bus   (bus.slave)
  );

  int cyc = 0, run_cyc = 0, bs = 2, be = 51;
  int n_pass = 0, n_checks = 0, overlap = 0, run_wide = 0, n_seen = 0;
  bit armed = 1'b0, busy_en = 1'b1, prev_run = 1'b0;
  logic [FUNC_W-1:0] run_q[$];
  done_t done_q[$];
  logic [FUNC_W-1:0] t2_exp [6] = '{4'hE, 4'h5, 4'h7, 4'h9, 4'h1, 4'h2};

  // Sequencer model and observers, sampled 1 time unit after each rising edge.
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (!rstn || swrst) armed = 1'b0;
    if (bus.run === 1'b1) begin
      if (prev_run) run_wide++;
      run_cyc = cyc;
      armed   = 1'b1;
      run_q.push_back(bus.n_func);
    end
    prev_run = (bus.run === 1'b1);
    bus.seq_busy = armed && busy_en && (cyc - run_cyc >= bs) && (cyc - run_cyc <= be);
    if (bus.host_grant === 1'b1 && (bus.run === 1'b1 || bus.seq_busy)) overlap++;
    if (bus.done === 1'b1) done_q.push_back('{bus.done_func, bus.done_cycles, bus.err, cyc});
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push(input logic [FUNC_W-1:0] f, output int drv_cyc);
    drv_cyc       = cyc;
    bus.cmd_func  = f;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output done_t d);
    int k = 0;
    while (done_q.size() <= n_seen && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_done_seen"}, done_q.size() > n_seen, 1);
    if (done_q.size() > n_seen) begin
      d = done_q[n_seen];
      n_seen++;
    end else begin
      d = '{default: 0};
    end
    $display("done %s: func=%0h cycles=%0d err=%0b", name, d.func, d.cycles, d.err);
  endtask

  initial begin
    vec_t  vt [5];
    done_t d;
    int    dc, k, base, nd;
    bit    launch_ready;

    bus.cmd_valid = 1'b0;
    bus.cmd_func  = '0;
    bus.host_req  = 1'b0;
    vt[0] = '{4'h3, 2, 51, 1'b1, 52, 1'b0};
    vt[1] = '{4'h6, 1, 1,  1'b1, 2,  1'b0};
    vt[2] = '{4'hA, 8, 10, 1'b1, 11, 1'b0};
    vt[3] = '{4'hC, 5, 20, 1'b1, 21, 1'b0};
    vt[4] = '{4'hF, 3, 3,  1'b1, 4,  1'b0};

    repeat (3) @(negedge clk);
    chk("rst_run", bus.run, 0);
    chk("rst_idle", bus.idle, 1);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_grant", bus.host_grant, 0);
    chk("rst_n_func", bus.n_func, 0);
    chk("rst_done_cycles", bus.done_cycles, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Single commands with different busy windows, including busy arriving at START_TMO.
    for (int i = 0; i < 5; i++) begin
      bs = vt[i].bs; be = vt[i].be; busy_en = vt[i].busy_en;
      base = run_q.size();
      push(vt[i].func, dc);
      wait_done($sformatf("v%0d", i), 200, d);
      chk($sformatf("v%0d_one_run", i), run_q.size() - base, 1);
      chk($sformatf("v%0d_run_lat", i), run_cyc - dc, 2);
      chk($sformatf("v%0d_n_func", i), run_q[base], vt[i].func);
      chk($sformatf("v%0d_done_func", i), d.func, vt[i].func);
      chk($sformatf("v%0d_cycles", i), d.cycles, vt[i].exp_cycles);
      chk($sformatf("v%0d_done_lat", i), d.at - run_cyc, vt[i].exp_cycles + 1);
      chk($sformatf("v%0d_err", i), d.err, vt[i].exp_err);
      @(negedge clk);
      chk($sformatf("v%0d_idle", i), bus.idle, 1);
    end

    // FIFO fills behind a long run; a held fifth push waits for the first pop.
    bs = 1; be = 40; busy_en = 1'b1;
    base = run_q.size();
    push(4'hE, dc);
    repeat (3) @(negedge clk);
    push(4'h5, dc); push(4'h7, dc); push(4'h9, dc); push(4'h1, dc);
    chk("t2_full_ready", bus.cmd_ready, 0);
    chk("t2_not_idle", bus.idle, 0);
    bus.cmd_func = 4'h2; bus.cmd_valid = 1'b1;
    k = 0; launch_ready = 1'b0;
    while (!bus.cmd_ready && k < 200) begin
      @(negedge clk);
      k++;
      if (bus.run && bus.cmd_ready) launch_ready = 1'b1;
    end
    chk("t2_ready_returns", bus.cmd_ready, 1);
    chk("t2_no_push_in_pop_cycle", launch_ready, 0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int j = 0; j < 6; j++) begin
      wait_done($sformatf("t2_%0d", j), 100, d);
      chk($sformatf("t2_done_func%0d", j), d.func, t2_exp[j]);
    end
    for (int j = 0; j < 6; j++) chk($sformatf("t2_run_order%0d", j), run_q[base + j], t2_exp[j]);
    @(negedge clk);
    chk("t2_idle", bus.idle, 1);

    // Host session with queued work: one launch is forced between grants.
    bs = 1; be = 3;
    bus.host_req = 1'b1;
    k = 0;
    while (!bus.host_grant && k < 20) begin @(negedge clk); k++; end
    chk("t3_grant", bus.host_grant, 1);
    base = run_q.size();
    push(4'h8, dc); push(4'hB, dc);
    repeat (5) @(negedge clk);
    chk("t3_no_launch_in_host", run_q.size() - base, 0);
    chk("t3_grant_held", bus.host_grant, 1);
    bus.host_req = 1'b0;
    @(negedge clk);
    chk("t3_grant_drop", bus.host_grant, 0);
    bus.host_req = 1'b1;
    k = 0;
    while (!bus.host_grant && k < 40) begin @(negedge clk); k++; end
    chk("t3_regrant", bus.host_grant, 1);
    chk("t3_one_launch_between", run_q.size() - base, 1);
    chk("t3_first_func", run_q[base], 4'h8);
    wait_done("t3a", 20, d);
    chk("t3a_func", d.func, 4'h8);
    bus.host_req = 1'b0;
    wait_done("t3b", 40, d);
    chk("t3b_func", d.func, 4'hB);
    chk("t3_second_run", run_q[base + 1], 4'hB);

    // Busy never rises: timeout, then the queued command still runs; err is sticky.
    busy_en = 1'b0;
    push(4'h4, dc); push(4'hD, dc);
    wait_done("t4a", 50, d);
    chk("t4a_func", d.func, 4'h4);
    chk("t4a_cycles", d.cycles, START_TMO);
    chk("t4a_err", d.err, 1);
    busy_en = 1'b1; bs = 1; be = 2;
    wait_done("t4b", 50, d);
    chk("t4b_func", d.func, 4'hD);
    chk("t4b_cycles", d.cycles, 3);
    repeat (3) @(negedge clk);
    chk("t4_err_sticky", bus.err, 1);

    // Soft reset in the middle of a run with two commands queued.
    bs = 1; be = 200;
    base = run_q.size();
    push(4'h6, dc); push(4'h7, dc); push(4'h8, dc);
    repeat (5) @(negedge clk);
    chk("t5_running", bus.idle, 0);
    nd = done_q.size(); base = run_q.size();
    swrst = 1'b1;
    @(negedge clk);
    swrst = 1'b0;
    chk("t5_idle", bus.idle, 1);
    chk("t5_ready", bus.cmd_ready, 1);
    chk("t5_err", bus.err, 0);
    chk("t5_done_func", bus.done_func, 0);
    chk("t5_done_cycles", bus.done_cycles, 0);
    repeat (20) @(negedge clk);
    chk("t5_no_done", done_q.size() - nd, 0);
    chk("t5_no_runs", run_q.size() - base, 0);
    chk("t5_still_idle", bus.idle, 1);

    // Async reset while waiting for busy; outputs must clear without a clock edge.
    bs = 1; be = 2; busy_en = 1'b1;
    push(4'h9, dc);
    wait_done("t6a", 30, d);
    chk("t6a_cycles", d.cycles, 3);
    busy_en = 1'b0;
    push(4'h5, dc);
    repeat (3) @(negedge clk);
    chk("t6_in_wait", bus.idle, 0);
    chk("t6_n_func_before", bus.n_func, 4'h5);
    #2 rstn = 1'b0;
    #1;
    chk("t6_run", bus.run, 0);
    chk("t6_n_func", bus.n_func, 0);
    chk("t6_done_func", bus.done_func, 0);
    chk("t6_done_cycles", bus.done_cycles, 0);
    chk("t6_idle", bus.idle, 1);
    chk("t6_ready", bus.cmd_ready, 1);
    chk("t6_grant", bus.host_grant, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    chk("grant_overlap", overlap, 0);
    chk("run_single_cycle", run_wide, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
